// File: rtl/xillybus_rd_arbiter_if.sv
`default_nettype none
//============================================================================
// Module      : xillybus_rd_arbiter_if
// Description : Bundle of the two requester AR/R channels and the shared
//               AXI3 read master channel around xillybus_rd_arbiter.
//               "master" is the arbiter's own view (it masters m_axi_*),
//               "slave" is the view of the surrounding requesters/memory.
// Revision    : 1.0 - initial release
//============================================================================
interface xillybus_rd_arbiter_if #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 64
);
    // Requester 0 (Xillybus core)
    logic                          s0_arvalid;
    logic                          s0_arready;
    logic [C_M_AXI_ADDR_WIDTH-1:0] s0_araddr;
    logic [3:0]                    s0_arlen;
    logic [11:0]                   s0_arattr;
    logic                          s0_rvalid;
    logic                          s0_rready;

    // Requester 1 (second DMA engine)
    logic                          s1_arvalid;
    logic                          s1_arready;
    logic [C_M_AXI_ADDR_WIDTH-1:0] s1_araddr;
    logic [3:0]                    s1_arlen;
    logic [11:0]                   s1_arattr;
    logic                          s1_rvalid;
    logic                          s1_rready;

    // Read data shared by both requesters
    logic [C_M_AXI_DATA_WIDTH-1:0] s_rdata;
    logic [1:0]                    s_rresp;
    logic                          s_rlast;

    // AXI3 read master port
    logic                          m_axi_arvalid;
    logic                          m_axi_arready;
    logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr;
    logic [3:0]                    m_axi_arlen;
    logic [2:0]                    m_axi_arsize;
    logic [1:0]                    m_axi_arburst;
    logic [2:0]                    m_axi_arprot;
    logic [3:0]                    m_axi_arcache;
    logic                          m_axi_rvalid;
    logic                          m_axi_rready;
    logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata;
    logic [1:0]                    m_axi_rresp;
    logic                          m_axi_rlast;

    modport master (
        input  s0_arvalid, s0_araddr, s0_arlen, s0_arattr, s0_rready,
        input  s1_arvalid, s1_araddr, s1_arlen, s1_arattr, s1_rready,
        input  m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
        output s0_arready, s0_rvalid, s1_arready, s1_rvalid,
        output s_rdata, s_rresp, s_rlast,
        output m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize,
        output m_axi_arburst, m_axi_arprot, m_axi_arcache, m_axi_rready
    );

    modport slave (
        output s0_arvalid, s0_araddr, s0_arlen, s0_arattr, s0_rready,
        output s1_arvalid, s1_araddr, s1_arlen, s1_arattr, s1_rready,
        output m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
        input  s0_arready, s0_rvalid, s1_arready, s1_rvalid,
        input  s_rdata, s_rresp, s_rlast,
        input  m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize,
        input  m_axi_arburst, m_axi_arprot, m_axi_arcache, m_axi_rready
    );
endinterface
`default_nettype wire

// File: rtl/xillybus_rd_arbiter.sv
`default_nettype none
//============================================================================
// Module      : xillybus_rd_arbiter
// Description : Shares one AXI3 read master between two requesters.
//               Address requests are arbitrated (round-robin by default)
//               and registered onto m_axi_ar*; read bursts come back in
//               order and are steered by an owner-tag FIFO.
// Config      : XILLYBUS_RD_ARB_FIXED_PRIO_EN - when defined, s0 always
//               wins a tie (fixed priority) instead of round-robin.
// Revision    : 1.0 - initial release
//============================================================================
module xillybus_rd_arbiter #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 64,
    parameter int C_MAX_OUTSTANDING  = 4
) (
    input  wire                   bus_clk,
    input  wire                   bus_rst,
    xillybus_rd_arbiter_if.master bus,
    output logic [4:0]            outstanding
);

    localparam int               c_ptr_w    = (C_MAX_OUTSTANDING > 1) ? $clog2(C_MAX_OUTSTANDING) : 1;
    localparam logic [4:0]       c_max_cnt  = 5'(C_MAX_OUTSTANDING);
    localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(C_MAX_OUTSTANDING - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    state_t                          r_state;
    logic                            r_arvalid;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   r_araddr;
    logic [3:0]                      r_arlen;
    logic [11:0]                     r_arattr;
    logic [4:0]                      r_cnt;
    logic [C_MAX_OUTSTANDING-1:0]    r_tags;
    logic [c_ptr_w-1:0]              r_wr_ptr;
    logic [c_ptr_w-1:0]              r_rd_ptr;

    logic                            w_any_req;
    logic                            w_room;
    logic                            w_pick_s1;
    logic                            w_grant;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   w_sel_addr;
    logic [3:0]                      w_sel_len;
    logic [11:0]                     w_sel_attr;
    logic                            w_empty;
    logic                            w_head;
    logic                            w_rready;
    logic                            w_complete;
    logic [C_M_AXI_DATA_WIDTH-1:0]   w_rdata;

    // Wrap-around pointer step; depth need not fill the pointer range
    function automatic logic [c_ptr_w-1:0] ptr_next(input logic [c_ptr_w-1:0] p);
        return (p == c_last_ptr) ? '0 : p + 1'b1;
    endfunction

    //------------------------------------------------------------------------
    // Address arbitration
    //------------------------------------------------------------------------
    assign w_any_req = bus.s0_arvalid | bus.s1_arvalid;
    assign w_room    = (r_cnt < c_max_cnt);
    // Reset gates the grant so requesters never see arready while in reset
    assign w_grant   = !bus_rst && (r_state == ST_IDLE) && w_room && w_any_req;

`ifdef XILLYBUS_RD_ARB_FIXED_PRIO_EN
    // s1 is served only when s0 is not asking
    assign w_pick_s1 = !bus.s0_arvalid;
`else
    logic r_last_grant;   // 1: s1 was granted last (reset value so s0 wins the first tie)

    // On a tie, the requester not granted last wins
    assign w_pick_s1 = bus.s1_arvalid && (!bus.s0_arvalid || !r_last_grant);

    // Remember who won the most recent grant
    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            r_last_grant <= 1'b1;
        end else if (w_grant) begin
            r_last_grant <= w_pick_s1;
        end
    end
`endif

    assign w_sel_addr = w_pick_s1 ? bus.s1_araddr : bus.s0_araddr;
    assign w_sel_len  = w_pick_s1 ? bus.s1_arlen  : bus.s0_arlen;
    assign w_sel_attr = w_pick_s1 ? bus.s1_arattr : bus.s0_arattr;

    assign bus.s0_arready = w_grant & !w_pick_s1;
    assign bus.s1_arready = w_grant &  w_pick_s1;

    // AR state machine: latch the winner, then hold it until the slave accepts
    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            r_state   <= ST_IDLE;
            r_arvalid <= 1'b0;
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_arattr  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_araddr  <= w_sel_addr;
                        r_arlen   <= w_sel_len;
                        r_arattr  <= w_sel_attr;
                        r_arvalid <= 1'b1;
                        r_state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (bus.m_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_arvalid <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.m_axi_arvalid = r_arvalid;
    assign bus.m_axi_araddr  = r_araddr;
    assign bus.m_axi_arlen   = r_arlen;
    // arattr packing: {size[2:0], burst[1:0], prot[2:0], cache[3:0]}
    assign bus.m_axi_arsize  = r_arattr[11:9];
    assign bus.m_axi_arburst = r_arattr[8:7];
    assign bus.m_axi_arprot  = r_arattr[6:4];
    assign bus.m_axi_arcache = r_arattr[3:0];

    //------------------------------------------------------------------------
    // Read data routing (purely combinational, in-order bursts)
    //------------------------------------------------------------------------
    // The FIFO holds exactly one tag per in-flight burst, so the counter
    // doubles as its occupancy.
    assign w_empty    = (r_cnt == 5'd0);
    assign w_head     = r_tags[r_rd_ptr];
    assign w_rready   = !w_empty && (w_head ? bus.s1_rready : bus.s0_rready);
    assign w_complete = bus.m_axi_rvalid & w_rready & bus.m_axi_rlast;

    assign bus.m_axi_rready = w_rready;
    assign bus.s0_rvalid    = bus.m_axi_rvalid & !w_empty & !w_head;
    assign bus.s1_rvalid    = bus.m_axi_rvalid & !w_empty &  w_head;

    assign w_rdata     = bus.m_axi_rdata;
    assign bus.s_rdata = w_rdata;
    assign bus.s_rresp = bus.m_axi_rresp;
    assign bus.s_rlast = bus.m_axi_rlast;

    // Owner-tag FIFO and in-flight counter: push on grant, pop on last beat
    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            r_tags   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= 5'd0;
        end else begin
            if (w_grant) begin
                r_tags[r_wr_ptr] <= w_pick_s1;
                r_wr_ptr         <= ptr_next(r_wr_ptr);
            end
            if (w_complete) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({w_grant, w_complete})
                2'b10:   r_cnt <= r_cnt + 5'd1;
                2'b01:   r_cnt <= r_cnt - 5'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign outstanding = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_xillybus_rd_arbiter.sv
`default_nettype none
//============================================================================
// Module      : tb_xillybus_rd_arbiter
// Description : Directed self-checking bench for xillybus_rd_arbiter
//               (default round-robin build, C_MAX_OUTSTANDING = 4).
// Revision    : 1.0 - initial release
//============================================================================
module tb_xillybus_rd_arbiter;

    logic       clk;
    logic       rst;
    logic [4:0] outstanding;
    int         n_vec;
    int         n_miss;

    xillybus_rd_arbiter_if #(
        .C_M_AXI_ADDR_WIDTH (32),
        .C_M_AXI_DATA_WIDTH (64)
    ) bus ();

    xillybus_rd_arbiter #(
        .C_M_AXI_ADDR_WIDTH (32),
        .C_M_AXI_DATA_WIDTH (64),
        .C_MAX_OUTSTANDING  (4)
    ) dut (
        .bus_clk     (clk),
        .bus_rst     (rst),
        .bus         (bus),
        .outstanding (outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One R beat for the given owner, optionally preceded by a stall cycle
    // where only the other requester is ready.
    task automatic beat(input bit owner, input logic [63:0] data, input bit last, input bit stall);
        bus.m_axi_rvalid = 1'b1;
        bus.m_axi_rdata  = data;
        bus.m_axi_rlast  = last;
        if (stall) begin
            bus.s0_rready = owner;
            bus.s1_rready = !owner;
            #1;
            check("stall_m_rready", bus.m_axi_rready, 0);
            check("stall_own_rvalid", owner ? bus.s1_rvalid : bus.s0_rvalid, 1);
            tick;
        end
        bus.s0_rready = !owner;
        bus.s1_rready = owner;
        #1;
        check("own_rvalid",   owner ? bus.s1_rvalid : bus.s0_rvalid, 1);
        check("other_rvalid", owner ? bus.s0_rvalid : bus.s1_rvalid, 0);
        check("m_rready",     bus.m_axi_rready, 1);
        check("s_rdata",      bus.s_rdata, data);
        tick;
        bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rlast  = 1'b0;
        bus.s0_rready    = 1'b0;
        bus.s1_rready    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst    = 1'b1;
        bus.s0_arvalid = 0; bus.s0_araddr = '0; bus.s0_arlen = '0; bus.s0_arattr = '0; bus.s0_rready = 0;
        bus.s1_arvalid = 0; bus.s1_araddr = '0; bus.s1_arlen = '0; bus.s1_arattr = '0; bus.s1_rready = 0;
        bus.m_axi_arready = 0; bus.m_axi_rvalid = 0; bus.m_axi_rdata = '0;
        bus.m_axi_rresp = '0;  bus.m_axi_rlast = 0;

        // ---- Reset state ----
        tick; tick;
        check("rst_arvalid",     bus.m_axi_arvalid, 0);
        check("rst_araddr",      bus.m_axi_araddr, 0);
        check("rst_arlen",       bus.m_axi_arlen, 0);
        check("rst_arcache",     bus.m_axi_arcache, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_s0_arready",  bus.s0_arready, 0);
        check("rst_m_rready",    bus.m_axi_rready, 0);
        check("rst_s0_rvalid",   bus.s0_rvalid, 0);

        // ---- Single request: s0, addr 0x1000, len 3 ----
        rst = 1'b0;
        bus.s0_arvalid = 1; bus.s0_araddr = 32'h1000; bus.s0_arlen = 4'd3;
        bus.s0_arattr  = 12'h683;           // size 3, burst 1, prot 0, cache 3
        bus.m_axi_arready = 1;
        #1;
        check("single_s0_arready", bus.s0_arready, 1);
        check("single_s1_arready", bus.s1_arready, 0);
        tick;
        bus.s0_arvalid = 0;
        #1;
        check("single_arvalid",  bus.m_axi_arvalid, 1);
        check("single_araddr",   bus.m_axi_araddr, 32'h1000);
        check("single_arlen",    bus.m_axi_arlen, 3);
        check("single_arsize",   bus.m_axi_arsize, 3);
        check("single_arburst",  bus.m_axi_arburst, 1);
        check("single_arprot",   bus.m_axi_arprot, 0);
        check("single_arcache",  bus.m_axi_arcache, 3);
        check("single_out1",     outstanding, 1);
        check("single_issue_rdy", bus.s0_arready, 0);
        tick;
        check("single_arvalid_clr", bus.m_axi_arvalid, 0);
        for (int i = 0; i < 4; i++) begin
            beat(1'b0, 64'h1111_0000_0000_0000 + 64'(i), (i == 3), 1'b0);
            check("single_out_after_beat", outstanding, (i == 3) ? 0 : 1);
        end

        // ---- Contention: fresh pointer, both requesting continuously ----
        rst = 1'b1;
        tick; tick;
        rst = 1'b0;
        bus.s0_arvalid = 1; bus.s0_araddr = 32'h2000; bus.s0_arlen = 4'd1; bus.s0_arattr = 12'h683;
        bus.s1_arvalid = 1; bus.s1_araddr = 32'h3000; bus.s1_arlen = 4'd0; bus.s1_arattr = 12'h683;
        bus.m_axi_arready = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_s0_arready", bus.s0_arready, (k % 2 == 0));
            check("rr_s1_arready", bus.s1_arready, (k % 2 == 1));
            tick;
            check("rr_araddr", bus.m_axi_araddr, (k % 2 == 0) ? 32'h2000 : 32'h3000);
            check("rr_issue_noready", bus.s0_arready | bus.s1_arready, 0);
            tick;
        end

        // ---- Full: four bursts in flight, fifth request held off ----
        #1;
        check("full_out4",       outstanding, 4);
        check("full_s0_arready", bus.s0_arready, 0);
        check("full_s1_arready", bus.s1_arready, 0);
        tick;
        check("full_s0_arready2", bus.s0_arready | bus.s1_arready, 0);
        check("full_arvalid",     bus.m_axi_arvalid, 0);
        beat(1'b0, 64'hAAAA_0000_0000_0001, 1'b1, 1'b0);   // head burst belongs to s0
        #1;
        check("full_out3",         outstanding, 3);
        check("full_regrant_s0",   bus.s0_arready, 1);
        check("full_regrant_s1",   bus.s1_arready, 0);
        tick;
        bus.s0_arvalid = 0; bus.s1_arvalid = 0;
        #1;
        check("full_out4_again", outstanding, 4);
        tick;

        // ---- Ordering: queue now holds s1, s0, s1, s0 ----
        beat(1'b1, 64'hB1B1_0000_0000_0001, 1'b0, 1'b1);
        beat(1'b1, 64'hB1B1_0000_0000_0002, 1'b1, 1'b0);
        check("ord_out3", outstanding, 3);
        beat(1'b0, 64'hB0B0_0000_0000_0001, 1'b0, 1'b0);
        beat(1'b0, 64'hB0B0_0000_0000_0002, 1'b1, 1'b1);
        check("ord_out2", outstanding, 2);
        beat(1'b1, 64'hB1B1_0000_0000_0003, 1'b1, 1'b1);
        check("ord_out1", outstanding, 1);
        beat(1'b0, 64'hB0B0_0000_0000_0003, 1'b1, 1'b0);
        check("ord_out0", outstanding, 0);
        bus.m_axi_rvalid = 1; bus.s0_rready = 1; bus.s1_rready = 1;
        #1;
        check("empty_s0_rvalid", bus.s0_rvalid, 0);
        check("empty_s1_rvalid", bus.s1_rvalid, 0);
        check("empty_m_rready",  bus.m_axi_rready, 0);
        bus.m_axi_rvalid = 0; bus.s0_rready = 0; bus.s1_rready = 0;
        tick;

        // ---- Backpressure: arready low for 5 cycles ----
        bus.m_axi_arready = 0;
        bus.s1_arvalid = 1; bus.s1_araddr = 32'h4000; bus.s1_arlen = 4'd7;
        bus.s1_arattr  = 12'hABC;           // size 5, burst 1, prot 3, cache 0xC
        #1;
        check("bp_s1_arready", bus.s1_arready, 1);
        check("bp_s0_arready", bus.s0_arready, 0);
        tick;
        bus.s1_araddr = 32'hDEAD_0000; bus.s1_arlen = 4'd2; bus.s0_arvalid = 1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_arvalid", bus.m_axi_arvalid, 1);
            check("bp_araddr",  bus.m_axi_araddr, 32'h4000);
            check("bp_arlen",   bus.m_axi_arlen, 7);
            check("bp_attr",    {bus.m_axi_arsize, bus.m_axi_arburst, bus.m_axi_arprot, bus.m_axi_arcache}, 12'hABC);
            check("bp_noready", bus.s0_arready | bus.s1_arready, 0);
            tick;
        end
        bus.m_axi_arready = 1;
        #1;
        check("bp_arvalid_last", bus.m_axi_arvalid, 1);
        tick;
        #1;
        check("bp_idle_arvalid",  bus.m_axi_arvalid, 0);
        check("bp_next_s0_grant", bus.s0_arready, 1);
        check("bp_next_s1_grant", bus.s1_arready, 0);
        tick;
        check("bp_out2", outstanding, 2);

        // ---- Reset mid-burst (s1 burst at head, requests still asserted) ----
        bus.m_axi_rvalid = 1; bus.m_axi_rdata = 64'hCC; bus.s1_rready = 1;
        #1;
        check("mid_s1_rvalid", bus.s1_rvalid, 1);
        rst = 1'b1;
        tick;
        check("mid_rst_out",       outstanding, 0);
        check("mid_rst_arvalid",   bus.m_axi_arvalid, 0);
        check("mid_rst_araddr",    bus.m_axi_araddr, 0);
        check("mid_rst_arlen",     bus.m_axi_arlen, 0);
        check("mid_rst_arsize",    bus.m_axi_arsize, 0);
        check("mid_rst_arready",   bus.s0_arready | bus.s1_arready, 0);
        check("mid_rst_s0_rvalid", bus.s0_rvalid, 0);
        check("mid_rst_s1_rvalid", bus.s1_rvalid, 0);
        check("mid_rst_m_rready",  bus.m_axi_rready, 0);
        bus.m_axi_rvalid = 0; bus.s1_rready = 0;
        rst = 1'b0;
        #1;
        check("post_rst_s0_wins", bus.s0_arready, 1);
        check("post_rst_s1_loses", bus.s1_arready, 0);
        bus.s0_arvalid = 0; bus.s1_arvalid = 0;
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
